// File: rtl/qed_inst_dup_if.sv
// Fetch-side handshake between instruction fetch and the QED duplicator.
// An instruction transfers on a clock edge where inst_vld_i && inst_ready_o; inst_ready_o may depend combinationally on inst_i/inst_vld_i, and fetch holds inst_i until it transfers.
interface qed_inst_dup_if;
  logic [31:0] inst_i;
  logic        inst_vld_i;
  logic        inst_ready_o;

  modport master (output inst_i, output inst_vld_i, input inst_ready_o);
  modport slave  (input inst_i, input inst_vld_i, output inst_ready_o);
endinterface

// File: rtl/qed_inst_dup.sv
// QED instruction duplicator: issues originals on x0-x15 and queues their x16-x31 twins
// in a FIFO, releasing a twin whenever exec_dup_i asks for one.
module qed_inst_dup #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  qed_inst_dup_if.slave              fetch,
  input  logic                       exec_dup_i,
  input  logic                       stall_i,
  output logic [31:0]                inst_o,
  output logic                       qed_vld_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic [6:0]  opcode;
  logic        is_op, is_opimm, is_u;
  logic        supported, use_rs1, use_rs2, legal;
  logic [31:0] dup_inst;
  logic        do_pop, do_push;
  logic [31:0] inst_nxt;
  logic        qed_vld_nxt;

  assign opcode    = fetch.inst_i[6:0];
  assign is_op     = (opcode == 7'b0110011);
  assign is_opimm  = (opcode == 7'b0010011);
  assign is_u      = (opcode == 7'b0110111) || (opcode == 7'b0010111);
  assign supported = is_op || is_opimm || is_u;
  assign use_rs1   = is_op || is_opimm;
  assign use_rs2   = is_op;

  // An original must stay in x0-x15 so its twin cannot alias it; bit 4 of a used field marks x16+.
  assign legal = !(fetch.inst_i[11] || (use_rs1 && fetch.inst_i[19]) ||
                   (use_rs2 && fetch.inst_i[24]));

  always_comb begin
    dup_inst = fetch.inst_i;
    if (fetch.inst_i[11:7] != 5'd0)              dup_inst[11] = 1'b1;
    if (use_rs1 && fetch.inst_i[19:15] != 5'd0)  dup_inst[19] = 1'b1;
    if (use_rs2 && fetch.inst_i[24:20] != 5'd0)  dup_inst[24] = 1'b1;
  end

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;

  // Duplicate issue has priority; push and pop are mutually exclusive by construction.
  assign do_pop  = !stall_i && exec_dup_i && !empty_o;
  assign do_push = !stall_i && !do_pop && fetch.inst_vld_i && supported && legal && !full_o;

  // Fetch only holds when an original is waiting on a full queue, or the slot is taken.
  assign fetch.inst_ready_o = !stall_i && !do_pop && fetch.inst_vld_i &&
                              !(supported && legal && full_o);

  always_comb begin
    inst_nxt    = NOP;
    qed_vld_nxt = 1'b0;
    if (do_pop) begin
      inst_nxt    = mem[rptr];
      qed_vld_nxt = 1'b1;
    end else if (fetch.inst_vld_i) begin
      if (!supported) begin
        inst_nxt = fetch.inst_i;
      end else if (legal && !full_o) begin
        inst_nxt    = fetch.inst_i;
        qed_vld_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_o    <= NOP;
      qed_vld_o <= 1'b0;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
    end else if (!stall_i) begin
      inst_o    <= inst_nxt;
      qed_vld_o <= qed_vld_nxt;
      if (do_push) begin
        wptr  <= wptr + PW'(1);
        count <= count + CW'(1);
      end else if (do_pop) begin
        rptr  <= rptr + PW'(1);
        count <= count - CW'(1);
      end
    end
  end

  // Queue storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= dup_inst;
  end

endmodule

// File: tb/tb_qed_inst_dup.sv
// Directed bench for qed_inst_dup: duplicate remap, FIFO order, full/illegal/stall cases
// and asynchronous reset in mid-operation.
module tb_qed_inst_dup;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        exec_dup_i;
  logic        stall_i;
  logic [31:0] inst_o;
  logic        qed_vld_o;
  logic [3:0]  count_o;
  logic        full_o;
  logic        empty_o;

  int checks = 0;
  int errors = 0;

  qed_inst_dup_if bus ();

  qed_inst_dup #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch      (bus.slave),
    .exec_dup_i (exec_dup_i),
    .stall_i    (stall_i),
    .inst_o     (inst_o),
    .qed_vld_o  (qed_vld_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic drive(input logic vld, input logic [31:0] inst, input logic exec, input logic stall);
    bus.inst_vld_i = vld;
    bus.inst_i     = inst;
    exec_dup_i     = exec;
    stall_i        = stall;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #20;
    checks += 5;
    if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst got=%h exp=%h", inst_o, NOP); end
    if (qed_vld_o !== 1'b0) begin errors++; $display("FAIL reset_qed got=%b exp=0", qed_vld_o); end
    if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_o); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0051_0093, 1'b0, 1'b0);
    checks++;
    if (bus.inst_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", bus.inst_ready_o); end
    step();
    checks += 3;
    if (inst_o !== 32'h0051_0093) begin errors++; $display("FAIL single_orig got=%h exp=00510093", inst_o); end
    if (qed_vld_o !== 1'b1) begin errors++; $display("FAIL single_orig_qed got=%b exp=1", qed_vld_o); end
    if (count_o !== 4'd1) begin errors++; $display("FAIL single_count1 got=%0d exp=1", count_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (bus.inst_ready_o !== 1'b0) begin errors++; $display("FAIL single_pop_ready got=%b exp=0", bus.inst_ready_o); end
    step();
    checks += 4;
    if (inst_o !== 32'h0059_0893) begin errors++; $display("FAIL single_dup got=%h exp=00590893", inst_o); end
    if (qed_vld_o !== 1'b1) begin errors++; $display("FAIL single_dup_qed got=%b exp=1", qed_vld_o); end
    if (count_o !== 4'd0) begin errors++; $display("FAIL single_count0 got=%0d exp=0", count_o); end
    if (empty_o !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_order();
    drive(1'b1, 32'h0020_81B3, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0051_0093, 1'b0, 1'b0);
    step();
    checks++;
    if (count_o !== 4'd2) begin errors++; $display("FAIL order_count got=%0d exp=2", count_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checks++;
    if (inst_o !== 32'h0128_89B3) begin errors++; $display("FAIL order_dup0 got=%h exp=012889b3", inst_o); end
    step();
    checks++;
    if (inst_o !== 32'h0059_0893) begin errors++; $display("FAIL order_dup1 got=%h exp=00590893", inst_o); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    checks += 2;
    if (inst_o !== NOP) begin errors++; $display("FAIL order_idle got=%h exp=%h", inst_o, NOP); end
    if (qed_vld_o !== 1'b0) begin errors++; $display("FAIL order_idle_qed got=%b exp=0", qed_vld_o); end
  endtask

  task automatic test_full();
    logic [31:0] exp_q[$];
    logic [31:0] exp_inst;
    for (int k = 0; k < 8; k++) begin
      // ADDI x1,x2,k and its twin ADDI x17,x18,k
      drive(1'b1, 32'h0001_0093 | (32'(k) << 20), 1'b0, 1'b0);
      exp_q.push_back(32'h0009_0893 | (32'(k) << 20));
      step();
    end
    checks += 2;
    if (full_o !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", full_o); end
    if (count_o !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", count_o); end
    drive(1'b1, 32'h0081_0093, 1'b0, 1'b0);
    checks++;
    if (bus.inst_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus.inst_ready_o); end
    step();
    checks += 3;
    if (inst_o !== NOP) begin errors++; $display("FAIL full_nop got=%h exp=%h", inst_o, NOP); end
    if (qed_vld_o !== 1'b0) begin errors++; $display("FAIL full_qed got=%b exp=0", qed_vld_o); end
    if (count_o !== 4'd8) begin errors++; $display("FAIL full_hold_count got=%0d exp=8", count_o); end
    drive(1'b1, 32'h0081_0093, 1'b1, 1'b0);
    step();
    exp_inst = exp_q.pop_front();
    checks += 2;
    if (inst_o !== exp_inst) begin errors++; $display("FAIL full_pop got=%h exp=%h", inst_o, exp_inst); end
    if (count_o !== 4'd7) begin errors++; $display("FAIL full_pop_count got=%0d exp=7", count_o); end
    drive(1'b1, 32'h0081_0093, 1'b0, 1'b0);
    checks++;
    if (bus.inst_ready_o !== 1'b1) begin errors++; $display("FAIL full_retry_ready got=%b exp=1", bus.inst_ready_o); end
    exp_q.push_back(32'h0089_0893);
    step();
    checks += 3;
    if (inst_o !== 32'h0081_0093) begin errors++; $display("FAIL full_retry got=%h exp=00810093", inst_o); end
    if (qed_vld_o !== 1'b1) begin errors++; $display("FAIL full_retry_qed got=%b exp=1", qed_vld_o); end
    if (count_o !== 4'd8) begin errors++; $display("FAIL full_retry_count got=%0d exp=8", count_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      exp_inst = exp_q.pop_front();
      checks++;
      if (inst_o !== exp_inst) begin errors++; $display("FAIL full_drain%0d got=%h exp=%h", k, inst_o, exp_inst); end
    end
    checks++;
    if (empty_o !== 1'b1) begin errors++; $display("FAIL full_drain_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h0010_0893, 1'b0, 1'b0);
    checks++;
    if (bus.inst_ready_o !== 1'b1) begin errors++; $display("FAIL illegal_ready got=%b exp=1", bus.inst_ready_o); end
    step();
    checks += 3;
    if (inst_o !== NOP) begin errors++; $display("FAIL illegal_nop got=%h exp=%h", inst_o, NOP); end
    if (qed_vld_o !== 1'b0) begin errors++; $display("FAIL illegal_qed got=%b exp=0", qed_vld_o); end
    if (count_o !== 4'd0) begin errors++; $display("FAIL illegal_count got=%0d exp=0", count_o); end
    drive(1'b1, 32'h0020_8463, 1'b0, 1'b0);
    checks++;
    if (bus.inst_ready_o !== 1'b1) begin errors++; $display("FAIL unsup_ready got=%b exp=1", bus.inst_ready_o); end
    step();
    checks += 3;
    if (inst_o !== 32'h0020_8463) begin errors++; $display("FAIL unsup_pass got=%h exp=00208463", inst_o); end
    if (qed_vld_o !== 1'b0) begin errors++; $display("FAIL unsup_qed got=%b exp=0", qed_vld_o); end
    if (count_o !== 4'd0) begin errors++; $display("FAIL unsup_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h0020_81B3, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0051_0093, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0020_81B3, 1'b1, 1'b1);
    checks++;
    if (bus.inst_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", bus.inst_ready_o); end
    step();
    step();
    checks += 3;
    if (inst_o !== 32'h0051_0093) begin errors++; $display("FAIL stall_hold got=%h exp=00510093", inst_o); end
    if (qed_vld_o !== 1'b1) begin errors++; $display("FAIL stall_qed got=%b exp=1", qed_vld_o); end
    if (count_o !== 4'd2) begin errors++; $display("FAIL stall_count got=%0d exp=2", count_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checks++;
    if (inst_o !== 32'h0128_89B3) begin errors++; $display("FAIL stall_dup0 got=%h exp=012889b3", inst_o); end
    step();
    checks++;
    if (count_o !== 4'd0) begin errors++; $display("FAIL stall_drained got=%0d exp=0", count_o); end
    // LUI x5,0x12345 requested alongside exec_dup on an empty queue
    drive(1'b1, 32'h1234_52B7, 1'b1, 1'b0);
    checks++;
    if (bus.inst_ready_o !== 1'b1) begin errors++; $display("FAIL empty_req_ready got=%b exp=1", bus.inst_ready_o); end
    step();
    checks += 3;
    if (inst_o !== 32'h1234_52B7) begin errors++; $display("FAIL empty_req_orig got=%h exp=123452b7", inst_o); end
    if (qed_vld_o !== 1'b1) begin errors++; $display("FAIL empty_req_qed got=%b exp=1", qed_vld_o); end
    if (count_o !== 4'd1) begin errors++; $display("FAIL empty_req_count got=%0d exp=1", count_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    checks++;
    if (inst_o !== 32'h1234_5AB7) begin errors++; $display("FAIL lui_dup got=%h exp=12345ab7", inst_o); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h0020_81B3, 1'b0, 1'b0);
      step();
    end
    checks++;
    if (count_o !== 4'd5) begin errors++; $display("FAIL mid_pre_count got=%0d exp=5", count_o); end
    #2;
    rst = 1'b0;
    #1;
    checks += 3;
    if (count_o !== 4'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count_o); end
    if (inst_o !== NOP) begin errors++; $display("FAIL mid_inst got=%h exp=%h", inst_o, NOP); end
    if (empty_o !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty_o); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks += 2;
      if (qed_vld_o !== 1'b0) begin errors++; $display("FAIL mid_post_qed%0d got=%b exp=0", k, qed_vld_o); end
      if (inst_o !== NOP) begin errors++; $display("FAIL mid_post_inst%0d got=%h exp=%h", k, inst_o, NOP); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_full();
    test_illegal();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
